// File: rtl/conv2x2_window_sched_if.sv
// Bus bundle between the window sequencer, its pixel-column source,
// the 4-lane 2x2 conv core and the result sink.
interface conv2x2_window_sched_if #(
    parameter int unsigned AW = 8
);
    logic          rd_en;
    logic [AW-1:0] rd_row;
    logic [AW-1:0] rd_col;
    logic [15:0]   rd_data;
    logic [79:0]   core_image;
    logic [31:0]   core_filter;
    logic [63:0]   core_conv_out;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [3:0]    out_mask;
    logic [AW-1:0] out_row;
    logic [AW-1:0] out_col;
    logic          out_last;

    modport master (
        output rd_en, rd_row, rd_col,
        input  rd_data,
        output core_image, core_filter,
        input  core_conv_out,
        output out_valid, out_data, out_mask, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_row, rd_col,
        output rd_data,
        input  core_image, core_filter,
        output core_conv_out,
        input  out_valid, out_data, out_mask, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/conv2x2_window_sched.sv
// Window sequencer for the 4-lane 2x2 conv core: walks the image in row pairs,
// builds 5-column windows, waits the core latency and emits masked result beats.
module conv2x2_window_sched #(
    parameter int unsigned IMG_W    = 16,
    parameter int unsigned IMG_H    = 16,
    parameter int unsigned CORE_LAT = 2,
    parameter int unsigned AW       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [31:0]            filter_in_i,
    output logic                   busy_o,
    output logic                   done_o,
    conv2x2_window_sched_if.master bus
);
    localparam int unsigned      LAT_W   = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam int unsigned      LAST_OC = IMG_W - 2;
    localparam int unsigned      LAST_OR = IMG_H - 2;
    localparam logic [LAT_W-1:0] LAT_END = LAT_W'(CORE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DRAIN, S_COMPUTE, S_OUTPUT, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     row_q, row_d;
    logic [AW-1:0]     base_q, base_d;
    logic [AW-1:0]     col_q, col_d;
    logic              rd_en_q, rd_en_d;
    logic              cap_vld_q;
    logic [2:0]        cap_slot_q;
    logic [4:0][15:0]  win_q, win_d;
    logic [31:0]       filt_q, filt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [63:0]       out_data_q, out_data_d;
    logic [3:0]        out_mask_q, out_mask_d;

    logic              enter_fetch;
    logic [AW-1:0]     ent_row, ent_base, first_col;
    logic [31:0]       nxt_col;
    logic              more_grp;

    // Another group of 4 output columns follows the current one in this row.
    assign more_grp = (32'(base_q) + 32'd4) <= LAST_OC;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        base_d      = base_q;
        col_d       = col_q;
        rd_en_d     = 1'b0;
        win_d       = win_q;
        filt_d      = filt_q;
        lat_d       = lat_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        enter_fetch = 1'b0;
        ent_row     = row_q;
        ent_base    = base_q;
        first_col   = '0;
        nxt_col     = 32'(col_q) + 32'd1;

        if (cap_vld_q) begin
            win_d[cap_slot_q] = bus.rd_data;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    filt_d      = filter_in_i;
                    busy_d      = 1'b1;
                    enter_fetch = 1'b1;
                    ent_row     = '0;
                    ent_base    = '0;
                end
            end
            S_FETCH: begin
                if (!rd_en_q) begin
                    state_d = S_COMPUTE;
                    lat_d   = '0;
                end else if ((nxt_col < IMG_W) && (nxt_col <= 32'(base_q) + 32'd4)) begin
                    rd_en_d = 1'b1;
                    col_d   = AW'(nxt_col);
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_COMPUTE;
                lat_d   = '0;
            end
            S_COMPUTE: begin
                if (lat_q == LAT_END) begin
                    out_data_d  = bus.core_conv_out;
                    out_valid_d = 1'b1;
                    for (int j = 0; j < 4; j++) begin
                        out_mask_d[j] = (32'(base_q) + 32'(j)) <= LAST_OC;
                    end
                    out_last_d = (32'(row_q) == LAST_OR) && !more_grp;
                    state_d    = S_OUTPUT;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else if (more_grp) begin
                        enter_fetch = 1'b1;
                        ent_base    = base_q + AW'(4);
                    end else begin
                        enter_fetch = 1'b1;
                        ent_row     = row_q + AW'(1);
                        ent_base    = '0;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Group setup: fresh 5-column load at row start, else reuse the shared column.
        if (enter_fetch) begin
            state_d = S_FETCH;
            row_d   = ent_row;
            base_d  = ent_base;
            if (ent_base == '0) begin
                win_d     = '0;
                first_col = '0;
            end else begin
                win_d[0]   = win_q[4];
                win_d[4:1] = '0;
                first_col  = ent_base + AW'(1);
            end
            col_d   = first_col;
            rd_en_d = 32'(first_col) < IMG_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            base_q      <= '0;
            col_q       <= '0;
            rd_en_q     <= 1'b0;
            cap_vld_q   <= 1'b0;
            cap_slot_q  <= '0;
            win_q       <= '0;
            filt_q      <= '0;
            lat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            base_q      <= base_d;
            col_q       <= col_d;
            rd_en_q     <= rd_en_d;
            cap_vld_q   <= rd_en_q;
            cap_slot_q  <= 3'(col_q - base_q);
            win_q       <= win_d;
            filt_q      <= filt_d;
            lat_q       <= lat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_row      = row_q;
    assign bus.rd_col      = col_q;
    assign bus.core_image  = win_q;
    assign bus.core_filter = filt_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_mask    = out_mask_q;
    assign bus.out_row     = row_q;
    assign bus.out_col     = base_q;
    assign bus.out_last    = out_last_q;
endmodule

// File: tb/tb_conv2x2_window_sched.sv
// Directed bench for conv2x2_window_sched: an 8x3 / latency-2 instance and a
// 5x2 / latency-4 instance, each with a pixel memory and a conv core stand-in.
module tb_conv2x2_window_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        start8, start5;
    logic [31:0] filt8, filt5;
    logic        busy8, done8, busy5, done5;
    logic        rdy8, rdy5;
    logic [15:0] rdd8, rdd5;
    logic [63:0] p8, p5a, p5b, p5c;

    conv2x2_window_sched_if #(.AW(8)) b8 ();
    conv2x2_window_sched_if #(.AW(8)) b5 ();

    conv2x2_window_sched #(.IMG_W(8), .IMG_H(3), .CORE_LAT(2), .AW(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .filter_in_i(filt8),
        .busy_o(busy8), .done_o(done8), .bus(b8)
    );

    conv2x2_window_sched #(.IMG_W(5), .IMG_H(2), .CORE_LAT(4), .AW(8)) u_dut5 (
        .clk(clk), .rst(rst), .start_i(start5), .filter_in_i(filt5),
        .busy_o(busy5), .done_o(done5), .bus(b5)
    );

    function automatic logic [7:0] pix(input logic [7:0] r, input logic [7:0] c);
        return 8'(32'(r) * 32'd8 + 32'(c));
    endfunction

    // Taps: [7:0] top(j), [15:8] top(j+1), [23:16] bottom(j), [31:24] bottom(j+1).
    function automatic logic [63:0] conv(input logic [79:0] img, input logic [31:0] f);
        logic [63:0] r;
        logic [15:0] a, b;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            a = img[16*j +: 16];
            b = img[16*(j+1) +: 16];
            r[16*j +: 16] = 16'(f[7:0])   * 16'(a[7:0])  + 16'(f[15:8])  * 16'(b[7:0]) +
                            16'(f[23:16]) * 16'(a[15:8]) + 16'(f[31:24]) * 16'(b[15:8]);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        rdd8 <= b8.rd_en ? {pix(8'(b8.rd_row + 8'd1), b8.rd_col), pix(b8.rd_row, b8.rd_col)} : 16'hDEAD;
        rdd5 <= b5.rd_en ? {pix(8'(b5.rd_row + 8'd1), b5.rd_col), pix(b5.rd_row, b5.rd_col)} : 16'hDEAD;
        p8   <= conv(b8.core_image, b8.core_filter);
        p5a  <= conv(b5.core_image, b5.core_filter);
        p5b  <= p5a;
        p5c  <= p5b;
    end

    assign b8.rd_data       = rdd8;
    assign b8.core_conv_out = p8;
    assign b8.out_ready     = rdy8;
    assign b5.rd_data       = rdd5;
    assign b5.core_conv_out = p5c;
    assign b5.out_ready     = rdy5;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one beat of the 8-wide instance: logs reads, checks the beat, optional stall, handshake.
    task automatic beat8(input string tag, input logic [7:0] erow, input logic [7:0] ecol,
                         input logic [3:0] emask, input logic [63:0] edata, input logic elast,
                         input int nrd, input logic [63:0] esig, input int stall, input logic pulse);
        int          n      = 0;
        int          gap    = 0;
        int          cnt    = 0;
        logic [63:0] sig    = '0;
        logic        rowbad = 1'b0;
        logic        stable = 1'b1;
        logic        quiet  = 1'b1;
        logic [63:0] hd;
        logic [3:0]  hm;
        logic [7:0]  hr, hc;
        rdy8 = (stall == 0);
        if (pulse) begin
            start8 = 1'b1;
            filt8  = 32'hAAAA_AAAA;
        end
        while (!b8.out_valid && n < 200) begin
            if (b8.rd_en) begin
                cnt++;
                sig = {sig[55:0], b8.rd_col};
                if (b8.rd_row !== erow) rowbad = 1'b1;
                gap = 0;
            end else begin
                gap++;
            end
            step();
            start8 = 1'b0;
            n++;
        end
        check({tag, ":timeout"}, 64'(n >= 200), 64'd0);
        if (n >= 200) return;
        check({tag, ":data"},  b8.out_data, edata);
        check({tag, ":mask"},  64'(b8.out_mask), 64'(emask));
        check({tag, ":row"},   64'(b8.out_row), 64'(erow));
        check({tag, ":col"},   64'(b8.out_col), 64'(ecol));
        check({tag, ":last"},  64'(b8.out_last), 64'(elast));
        check({tag, ":nrd"},   64'(cnt), 64'(nrd));
        check({tag, ":rdcols"}, sig, esig);
        check({tag, ":rdrow"}, 64'(rowbad), 64'd0);
        check({tag, ":lat"},   64'(gap), 64'd3);
        hd = b8.out_data;
        hm = b8.out_mask;
        hr = b8.out_row;
        hc = b8.out_col;
        for (int i = 0; i < stall; i++) begin
            step();
            if (!b8.out_valid || b8.out_data !== hd || b8.out_mask !== hm ||
                b8.out_row !== hr || b8.out_col !== hc) stable = 1'b0;
            if (b8.rd_en) quiet = 1'b0;
        end
        if (stall > 0) begin
            check({tag, ":stall_stable"}, 64'(stable), 64'd1);
            check({tag, ":stall_no_rd"},  64'(quiet),  64'd1);
        end
        rdy8 = 1'b1;
        step();
        check({tag, ":vld_drop"}, 64'(b8.out_valid), 64'd0);
    endtask

    task automatic frame8_done(input string tag);
        check({tag, ":done"}, 64'(done8), 64'd1);
        check({tag, ":busy_off"}, 64'(busy8), 64'd0);
        step();
        check({tag, ":done_pulse"}, 64'(done8), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        int          gap;
        int          cnt;
        logic [63:0] sig;
        logic        bad;

        rst = 1'b1; start8 = 1'b0; start5 = 1'b0;
        filt8 = '0; filt5 = '0; rdy8 = 1'b1; rdy5 = 1'b1;
        repeat (3) step();
        check("rst:busy",    64'(busy8), 64'd0);
        check("rst:done",    64'(done8), 64'd0);
        check("rst:rd_en",   64'(b8.rd_en), 64'd0);
        check("rst:valid",   64'(b8.out_valid), 64'd0);
        check("rst:last",    64'(b8.out_last), 64'd0);
        check("rst:image",   64'(b8.core_image[79:16]) | 64'(b8.core_image[15:0]), 64'd0);
        check("rst:filter",  64'(b8.core_filter), 64'd0);
        check("rst:data",    b8.out_data, 64'd0);
        check("rst5:valid",  64'(b5.out_valid), 64'd0);
        rst = 1'b0;
        step();

        // Frame A: stall on beat 2, stray start and new filter_in mid-frame
        filt8 = 32'h0101_0101; start8 = 1'b1;
        step();
        start8 = 1'b0; filt8 = 32'hAAAA_AAAA;
        check("A:busy", 64'(busy8), 64'd1);
        beat8("A0", 8'd0, 8'd0, 4'hF, 64'h001E_001A_0016_0012, 1'b0, 5, 64'h0102_0304, 0,  1'b0);
        beat8("A1", 8'd0, 8'd4, 4'h7, 64'h0016_002A_0026_0022, 1'b0, 3, 64'h05_0607,   10, 1'b1);
        check("A:filter_held", 64'(b8.core_filter), 64'h0101_0101);
        beat8("A2", 8'd1, 8'd0, 4'hF, 64'h003E_003A_0036_0032, 1'b0, 5, 64'h0102_0304, 0,  1'b0);
        beat8("A3", 8'd1, 8'd4, 4'h7, 64'h0026_004A_0046_0042, 1'b1, 3, 64'h05_0607,   0,  1'b0);
        frame8_done("A");
        check("A:idle_after", 64'(busy8), 64'd0);

        // Frame B: reset during COMPUTE of beat 3
        filt8 = 32'h0101_0101; start8 = 1'b1;
        step();
        start8 = 1'b0;
        beat8("B0", 8'd0, 8'd0, 4'hF, 64'h001E_001A_0016_0012, 1'b0, 5, 64'h0102_0304, 0, 1'b0);
        beat8("B1", 8'd0, 8'd4, 4'h7, 64'h0016_002A_0026_0022, 1'b0, 3, 64'h05_0607,   0, 1'b0);
        n = 0;
        while (!b8.rd_en && n < 50) begin step(); n++; end
        while (b8.rd_en && n < 50) begin step(); n++; end
        check("B:reach_drain", 64'(n >= 50), 64'd0);
        step();
        rst = 1'b1;
        step();
        check("B:rst_busy",   64'(busy8), 64'd0);
        check("B:rst_done",   64'(done8), 64'd0);
        check("B:rst_rd_en",  64'(b8.rd_en), 64'd0);
        check("B:rst_valid",  64'(b8.out_valid), 64'd0);
        check("B:rst_data",   b8.out_data, 64'd0);
        check("B:rst_mask",   64'(b8.out_mask), 64'd0);
        check("B:rst_row",    64'(b8.out_row), 64'd0);
        check("B:rst_col",    64'(b8.out_col), 64'd0);
        check("B:rst_last",   64'(b8.out_last), 64'd0);
        check("B:rst_image",  64'(b8.core_image[79:16]) | 64'(b8.core_image[15:0]), 64'd0);
        check("B:rst_filter", 64'(b8.core_filter), 64'd0);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done8 || busy8 || b8.out_valid || b8.rd_en) bad = 1'b1;
        end
        check("B:quiet_after_rst", 64'(bad), 64'd0);

        // Frame C: clean frame after the abort
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        beat8("C0", 8'd0, 8'd0, 4'hF, 64'h001E_001A_0016_0012, 1'b0, 5, 64'h0102_0304, 0, 1'b0);
        beat8("C1", 8'd0, 8'd4, 4'h7, 64'h0016_002A_0026_0022, 1'b0, 3, 64'h05_0607,   0, 1'b0);
        beat8("C2", 8'd1, 8'd0, 4'hF, 64'h003E_003A_0036_0032, 1'b0, 5, 64'h0102_0304, 0, 1'b0);
        beat8("C3", 8'd1, 8'd4, 4'h7, 64'h0026_004A_0046_0042, 1'b1, 3, 64'h05_0607,   0, 1'b0);
        frame8_done("C");

        // 5x2 image, latency 4: single full beat with weighted taps
        filt5 = 32'h0403_0201; start5 = 1'b1;
        step();
        start5 = 1'b0;
        n = 0; gap = 0; cnt = 0; sig = '0;
        while (!b5.out_valid && n < 100) begin
            if (b5.rd_en) begin
                cnt++;
                sig = {sig[55:0], b5.rd_col};
                gap = 0;
            end else begin
                gap++;
            end
            step();
            n++;
        end
        check("W5:timeout", 64'(n >= 100), 64'd0);
        check("W5:data",   b5.out_data, 64'h005C_0052_0048_003E);
        check("W5:mask",   64'(b5.out_mask), 64'hF);
        check("W5:last",   64'(b5.out_last), 64'd1);
        check("W5:row",    64'(b5.out_row), 64'd0);
        check("W5:col",    64'(b5.out_col), 64'd0);
        check("W5:nrd",    64'(cnt), 64'd5);
        check("W5:rdcols", sig, 64'h0102_0304);
        check("W5:lat",    64'(gap), 64'd5);
        check("W5:filter", 64'(b5.core_filter), 64'h0403_0201);
        step();
        check("W5:done",      64'(done5), 64'd1);
        check("W5:vld_drop",  64'(b5.out_valid), 64'd0);
        step();
        check("W5:done_pulse", 64'(done5), 64'd0);
        check("W5:busy_off",   64'(busy5), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/conv2x2_window_sched.md
Name: conv2x2_window_sched

Overview:
- Sequencer that feeds the 4-lane 2x2 convolution datapath (80-bit window in, 4x16-bit results out) from a two-row pixel buffer.
- Walks an IMG_W x IMG_H 8-bit image in row pairs, stride 1. Builds 5-column windows, reusing the overlapping column between groups of 4 outputs.
- Waits the datapath latency, then presents each 4-result group on a valid/ready output with a lane mask and coordinates.
- Sits between the line-buffer controller and the result writer.

Parameters:
- IMG_W, 16, image width in pixels (>=2). Output width is IMG_W-1.
- IMG_H, 16, image height in pixels (>=2). Output height is IMG_H-1.
- CORE_LAT, 2, cycles from a stable core_image to a valid core_conv_out (>=1).
- AW, 8, width of the row and column address fields.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; starts a frame when idle
- filter_in  in  32  four 8-bit taps; latched on an accepted start
- busy  out  1  high from an accepted start until done
- done  out  1  one-cycle pulse after the last output beat is accepted
- rd_en  out  1  pixel-column read strobe
- rd_row  out  AW  top row r of the pair being read
- rd_col  out  AW  column c being read
- rd_data  in  16  {pix(r+1,c), pix(r,c)}; valid exactly 1 cycle after rd_en
- core_image  out  80  window column k at bits [16k+15:16k], k=0..4
- core_filter  out  32  latched filter
- core_conv_out  in  64  lane j result at bits [16j+15:16j]
- out_valid  out  1  result beat valid
- out_ready  in  1  sink accepts the beat
- out_data  out  64  registered copy of core_conv_out
- out_mask  out  4  bit j set when lane j is a real output column
- out_row  out  AW  output row
- out_col  out  AW  output column of lane 0
- out_last  out  1  final beat of the frame

Behaviour:
- Reset values: busy, done, rd_en, out_valid and out_last = 0; every bus = 0; window and filter registers = 0; FSM = IDLE. Reset mid-frame aborts immediately; no done pulse.
- States: IDLE, FETCH, DRAIN, COMPUTE, OUTPUT, DONE.
- IDLE: on start, latch filter_in, set row=0 and grp=0, then go to FETCH. start in any other state is ignored.
- FETCH:
  - Group column base b = 4*grp.
  - grp=0: issue 5 reads for columns b..b+4.
  - grp>0: first copy window col4 to col0, then issue 4 reads for columns b+1..b+4.
  - Reads are back-to-back, one per cycle. Each returning rd_data is shifted into the next window slot.
  - A column >= IMG_W is not read; its slot is zero-filled.
  - After the last issued read, go to DRAIN.
- DRAIN: 1 cycle to capture the final rd_data. A group with no real reads skips straight to COMPUTE.
- COMPUTE:
  - core_image is held stable from the window register for CORE_LAT cycles.
  - On the last cycle, capture core_conv_out into out_data, set out_valid and go to OUTPUT.
- OUTPUT:
  - out_valid holds and all out_* stay stable until out_valid & out_ready. No new reads are issued while stalled.
  - out_mask bit j = (b+j <= IMG_W-2). out_row = row, out_col = b.
  - out_last = (row == IMG_H-2) and (last group of the row).
  - On handshake: if out_last, go to DONE. Else if more groups remain, grp++ and go to FETCH. Else row++, grp=0 and go to FETCH with a fresh 5-column load.
- Groups per row = ceil((IMG_W-1)/4).
- DONE: done=1 for 1 cycle, busy=0, return to IDLE. out_valid deasserts in the cycle after the handshake.
- core_filter is constant for the whole frame.
- No arithmetic is performed on pixels. The block sequences only; results pass through unmodified.

Test Plan:
- IMG_W=8, IMG_H=3, pix(r,c)=8r+c, filter taps all 1, out_ready=1 → 4 beats.
  - Row 0: col 0 data {30,26,22,18} mask 1111; col 4 data {x,42,38,34} mask 0111.
  - Row 1: values +32. out_last on beat 4 only; done 1 cycle later.
- Read-pattern check, same frame: group 0 issues reads for cols 0..4; group 1 issues reads for cols 5..7 only (col 8 zero-filled, never read). rd_data always 1 cycle after rd_en.
- Backpressure: hold out_ready=0 for 10 cycles on beat 2 → out_data, out_mask, out_row and out_col stable; rd_en=0 throughout; resumes correctly after release.
- start pulsed while busy, and a new filter_in value mid-frame → ignored; core_filter keeps the start-time value.
- Assert rst during COMPUTE of beat 3 → next cycle all outputs 0, FSM IDLE, no done pulse. A new start then runs a full clean frame.
- IMG_W=5, IMG_H=2, CORE_LAT=4 → a single beat with mask 1111, out_last=1. COMPUTE lasts exactly 4 cycles, measured from the DRAIN exit.
